// File: rtl/column_scanner.sv
// Serialises one packed column word into per-cell beats with valid/ready handshaking.
// Optional build macro: COLUMN_SCANNER_SKIP_EMPTY_EN (skip zero-valued cells).
module column_scanner #(
    parameter int CELLS  = 4,
    parameter int CELL_W = 3,
    localparam int SEL_W = (CELLS > 1) ? $clog2(CELLS) : 1,
    localparam int WORD_W = CELLS * CELL_W
) (
    input  logic              inClk,
    input  logic              inRst,
    input  logic              inStart,
    input  logic [WORD_W-1:0] inRead,
    input  logic              inReady,
    output logic              outValid,
    output logic [CELL_W-1:0] outCol,
    output logic [SEL_W-1:0]  outSel,
    output logic              outDone,
    output logic              outBusy,
    output logic              outErr
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic [WORD_W-1:0]   snap_q, snap_d;
    logic [SEL_W-1:0]    idx_q, idx_d;
    logic [CELL_W-1:0]   col_q, col_d;
    logic                valid_q, valid_d;
    logic                done_q, done_d;
    logic                busy_q, busy_d;
    logic                err_q, err_d;

    function automatic logic [CELL_W-1:0] cell_at(input logic [WORD_W-1:0] snap, input int idx);
        return snap[idx*CELL_W +: CELL_W];
    endfunction

`ifdef COLUMN_SCANNER_SKIP_EMPTY_EN
    // Lowest non-zero cell at or above 'from'; MSB flags whether one exists.
    function automatic logic [SEL_W:0] first_nz(input logic [WORD_W-1:0] snap, input int from);
        logic [SEL_W:0] res;
        res = {(SEL_W+1){1'b0}};
        for (int i = CELLS - 1; i >= 0; i--) begin
            res = ((i >= from) && (cell_at(snap, i) != {CELL_W{1'b0}})) ? {1'b1, SEL_W'(i)} : res;
        end
        return res;
    endfunction

    logic [SEL_W:0] nz_s;
`endif

    // Next-state and registered-output computation for the scan FSM.
    always_comb begin
        state_d = state_q;
        snap_d  = snap_q;
        idx_d   = idx_q;
        col_d   = col_q;
        valid_d = valid_q;
        done_d  = 1'b0;
        busy_d  = busy_q;
        err_d   = 1'b0;
`ifdef COLUMN_SCANNER_SKIP_EMPTY_EN
        nz_s    = {(SEL_W+1){1'b0}};
`endif
        case (state_q)
            IDLE: begin
                valid_d = 1'b0;
                busy_d  = 1'b0;
                if (inStart) begin
                    if (inRead == {WORD_W{1'b1}}) begin
                        err_d = 1'b1;
                    end else begin
                        snap_d = inRead;
                        busy_d = 1'b1;
`ifdef COLUMN_SCANNER_SKIP_EMPTY_EN
                        nz_s = first_nz(inRead, 0);
                        if (nz_s[SEL_W]) begin
                            state_d = SEND;
                            valid_d = 1'b1;
                            idx_d   = nz_s[SEL_W-1:0];
                            col_d   = cell_at(inRead, int'(nz_s[SEL_W-1:0]));
                        end else begin
                            state_d = DONE;
                            done_d  = 1'b1;
                            idx_d   = {SEL_W{1'b0}};
                            col_d   = {CELL_W{1'b0}};
                        end
`else
                        state_d = SEND;
                        valid_d = 1'b1;
                        idx_d   = {SEL_W{1'b0}};
                        col_d   = cell_at(inRead, 0);
`endif
                    end
                end else begin
                    err_d = 1'b0;
                end
            end
            SEND: begin
                if (valid_q && inReady) begin
`ifdef COLUMN_SCANNER_SKIP_EMPTY_EN
                    nz_s = first_nz(snap_q, int'(idx_q) + 1);
                    if (nz_s[SEL_W]) begin
                        idx_d = nz_s[SEL_W-1:0];
                        col_d = cell_at(snap_q, int'(nz_s[SEL_W-1:0]));
                    end else begin
                        state_d = DONE;
                        valid_d = 1'b0;
                        done_d  = 1'b1;
                        idx_d   = {SEL_W{1'b0}};
                        col_d   = {CELL_W{1'b0}};
                    end
`else
                    if (idx_q == SEL_W'(CELLS - 1)) begin
                        state_d = DONE;
                        valid_d = 1'b0;
                        done_d  = 1'b1;
                        idx_d   = {SEL_W{1'b0}};
                        col_d   = {CELL_W{1'b0}};
                    end else begin
                        idx_d = idx_q + {{(SEL_W-1){1'b0}}, 1'b1};
                        col_d = cell_at(snap_q, int'(idx_q) + 1);
                    end
`endif
                end else begin
                    state_d = SEND;
                end
            end
            DONE: begin
                state_d = IDLE;
                busy_d  = 1'b0;
                valid_d = 1'b0;
            end
            default: begin
                state_d = IDLE;
                snap_d  = {WORD_W{1'b0}};
                idx_d   = {SEL_W{1'b0}};
                col_d   = {CELL_W{1'b0}};
                valid_d = 1'b0;
                busy_d  = 1'b0;
            end
        endcase
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge inClk) begin
        if (inRst) begin
            state_q <= IDLE;
            snap_q  <= {WORD_W{1'b0}};
            idx_q   <= {SEL_W{1'b0}};
            col_q   <= {CELL_W{1'b0}};
            valid_q <= 1'b0;
            done_q  <= 1'b0;
            busy_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            snap_q  <= snap_d;
            idx_q   <= idx_d;
            col_q   <= col_d;
            valid_q <= valid_d;
            done_q  <= done_d;
            busy_q  <= busy_d;
            err_q   <= err_d;
        end
    end

    assign outValid = valid_q;
    assign outCol   = col_q;
    assign outSel   = idx_q;
    assign outDone  = done_q;
    assign outBusy  = busy_q;
    assign outErr   = err_q;

endmodule

// File: doc/column_scanner.md
COLUMN_SCANNER -- requirements
Module: column_scanner

Interface
REQ-001 The module SHALL have parameter CELLS, default 4, giving the number of cells in one packed column word.
REQ-002 The module SHALL have parameter CELL_W, default 3, giving the bit width of one cell value.
REQ-003 The module SHALL have port inClk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 The module SHALL have port inRst, input, 1 bit: reset, synchronous and active-high.
REQ-005 The module SHALL have port inStart, input, 1 bit: request to scan the current column word.
REQ-006 The module SHALL have port inRead, input, CELLS*CELL_W bits: packed column word from the column store; cell i occupies bits [i*CELL_W+CELL_W-1 : i*CELL_W].
REQ-007 The module SHALL have port inReady, input, 1 bit: the consumer accepts the current beat.
REQ-008 The module SHALL have port outValid, output, 1 bit: outCol and outSel carry a valid beat.
REQ-009 The module SHALL have port outCol, output, CELL_W bits: the cell value of the current beat.
REQ-010 The module SHALL have port outSel, output, clog2(CELLS) bits: the cell index of the current beat.
REQ-011 The module SHALL have port outDone, output, 1 bit: one-cycle pulse marking scan completion.
REQ-012 The module SHALL have port outBusy, output, 1 bit: a scan is in progress.
REQ-013 The module SHALL have port outErr, output, 1 bit: one-cycle pulse marking rejection of an uninitialised word.

Function
REQ-014 The module SHALL implement a state machine with states IDLE, SEND and DONE.
REQ-015 In IDLE with inStart=1 and inRead not all-ones, the module SHALL latch inRead into a snapshot, set the index to 0 and enter SEND at the same edge; outValid rises the next cycle.
REQ-016 In IDLE with inStart=1 and inRead all-ones (the store's uninitialised value), the module SHALL pulse outErr for exactly one cycle, stay in IDLE and emit no beat.
REQ-017 In SEND, outValid SHALL be 1, outSel SHALL equal the index and outCol SHALL equal the snapshot cell at that index.
REQ-018 A beat SHALL transfer only on an edge where outValid=1 and inReady=1; while inReady=0, outCol and outSel SHALL hold stable.
REQ-019 On transfer of cell index CELLS-1, the module SHALL enter DONE; otherwise the index SHALL increment by 1 with no wrap.
REQ-020 DONE SHALL last exactly one cycle with outDone=1, then return to IDLE.
REQ-021 outBusy SHALL be 1 in SEND and DONE and 0 in IDLE.
REQ-022 inStart in SEND or DONE SHALL be ignored, with no queueing.
REQ-023 Changes on inRead after the snapshot is taken SHALL NOT affect the beats in flight.
REQ-024 Minimum scan time SHALL be 1+CELLS+1 cycles from the start edge to the outDone cycle when inReady is held at 1.

Reset
REQ-025 When inRst=1 at an edge, the module SHALL enter IDLE, clear the index and snapshot, and drive outValid=0, outCol=0, outSel=0, outDone=0, outBusy=0 and outErr=0 from the next cycle.
REQ-026 Reset SHALL take priority over inStart and inReady, including mid-SEND; a partial scan is abandoned and produces no outDone.

Configuration
REQ-027 When macro COLUMN_SCANNER_SKIP_EMPTY_EN is defined, cells of value 0 SHALL be skipped with no beat and no extra cycle, the next non-zero cell SHALL be presented, and a snapshot with all cells zero SHALL go straight from the start edge to DONE.
REQ-028 When COLUMN_SCANNER_SKIP_EMPTY_EN is undefined, every cell SHALL be emitted, including zero cells.

Verification
REQ-029 inRead=12'h68D, start, inReady=1 -> beats (outSel,outCol) = (0,5),(1,1),(2,2),(3,3) on consecutive cycles, then outDone for one cycle.
REQ-030 12'h68D with inReady=0 for 3 cycles while outSel=1 -> outCol=1 and outSel=1 held for 4 cycles, no beat lost or duplicated, and outDone arrives 3 cycles later than in REQ-029.
REQ-031 inRead=12'hFFF, start -> outErr=1 for one cycle, outValid stays 0 and outBusy stays 0.
REQ-032 inRst=1 during the beat at outSel=2 -> all outputs are 0 on the next cycle, no outDone, and a new start on 12'h68D scans correctly from cell 0.
REQ-033 Start pulsed while outBusy=1, and inRead changed to 12'h000 mid-scan -> the original 12'h68D sequence completes unaltered and no second scan occurs.
REQ-034 With COLUMN_SCANNER_SKIP_EMPTY_EN defined, 12'h605 -> beats (0,5),(3,3) then outDone; 12'h000 -> outDone one cycle after start and no beats.
